window_gen_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator placed directly upstream of the 3x3 averaging blur. It accepts one RGB444 pixel per valid cycle in raster order from the camera capture path, and buffers the two previous lines in internal line memories. For every pixel whose full 3x3 neighbourhood lies inside the frame, it presents all nine pixels in parallel with a one-cycle valid strobe, ready for the combinational blur to consume.

---
 rtl/window_gen_pkg.sv | 14 +
 rtl/window_gen_3x3_line_buffer.sv | 27 ++
 rtl/window_gen_3x3.sv | 134 +++++++++++++
 tb/tb_window_gen_3x3.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_gen_pkg.sv
// Shared pixel format and default frame geometry.
// Used by capture, window generator and blur so they agree on sizes.
package window_gen_pkg;

  localparam int PIX_W_DEF = 12;
  localparam int CH_W      = 4;
  localparam int R_LSB     = 8;
  localparam int G_LSB     = 4;
  localparam int B_LSB     = 0;
  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;
  localparam int CNT_W     = 9;

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// Single-port line memory, read-before-write on the same address.
// Two instances are chained to hold the previous two lines.
module line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 12,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The read returns the old word; the new word lands on the edge.
  assign rd_data = mem[addr];

  // Write the accepted word; contents are never cleared.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator for the averaging blur.
// Emits one window strobe per interior pixel, one cycle after it arrives.
module window_gen_3x3
  import window_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             frame_start,
  output logic             out_valid,
  output logic [PIX_W-1:0] win_lu,
  output logic [PIX_W-1:0] win_mu,
  output logic [PIX_W-1:0] win_ru,
  output logic [PIX_W-1:0] win_lm,
  output logic [PIX_W-1:0] win_mm,
  output logic [PIX_W-1:0] win_rm,
  output logic [PIX_W-1:0] win_ld,
  output logic [PIX_W-1:0] win_md,
  output logic [PIX_W-1:0] win_rd,
  output logic [8:0]       out_row,
  output logic [8:0]       out_col,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    WAIT_SOF,
    ACTIVE,
    DONE
  } state_t;

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [8:0] LAST_COL = 9'(IMG_W - 1);
  localparam logic [8:0] LAST_ROW = 9'(IMG_H - 1);

  state_t           state;
  logic [8:0]       row;
  logic [8:0]       col;
  logic [8:0]       cur_row;
  logic [8:0]       cur_col;
  logic             accept;
  logic [PIX_W-1:0] tap_up;
  logic [PIX_W-1:0] tap_mid;

  // Position of the pixel on the bus; frame_start forces (0,0).
  always_comb begin
    accept  = in_valid && (frame_start || state == ACTIVE);
    cur_row = frame_start ? 9'd0 : row;
    cur_col = frame_start ? 9'd0 : col;
  end

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (AW)
  ) u_lb1 (
    .clk     (clk),
    .en      (accept),
    .addr    (cur_col[AW-1:0]),
    .wr_data (in_pixel),
    .rd_data (tap_mid)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (AW)
  ) u_lb2 (
    .clk     (clk),
    .en      (accept),
    .addr    (cur_col[AW-1:0]),
    .wr_data (tap_mid),
    .rd_data (tap_up)
  );

  // Frame FSM, raster counters, window shift and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_SOF;
      row        <= '0;
      col        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      win_lu     <= '0;
      win_mu     <= '0;
      win_ru     <= '0;
      win_lm     <= '0;
      win_mm     <= '0;
      win_rm     <= '0;
      win_ld     <= '0;
      win_md     <= '0;
      win_rd     <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        win_lu <= win_mu;
        win_mu <= win_ru;
        win_ru <= tap_up;
        win_lm <= win_mm;
        win_mm <= win_rm;
        win_rm <= tap_mid;
        win_ld <= win_md;
        win_md <= win_rd;
        win_rd <= in_pixel;
        if (cur_row >= 9'd2 && cur_col >= 9'd2) begin
          out_valid <= 1'b1;
          out_row   <= cur_row - 9'd1;
          out_col   <= cur_col - 9'd1;
        end
        if (cur_col == LAST_COL) begin
          col <= '0;
          row <= cur_row + 9'd1;
        end else begin
          col <= cur_col + 9'd1;
          row <= cur_row;
        end
        if (cur_row == LAST_ROW && cur_col == LAST_COL) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end else begin
          state <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: a 4x4 instance for the
// scenario tests and a 320x24 instance for back-to-back frames.
module tb_window_gen_3x3;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int BW = 320;
  localparam int BH = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_valid, a_fs;
  logic [11:0] a_pix;
  logic        a_ov, a_fd;
  logic [11:0] a_lu, a_mu, a_ru, a_lm, a_mm, a_rm, a_ld, a_md, a_rd;
  logic [8:0]  a_row, a_col;

  logic        b_valid, b_fs;
  logic [11:0] b_pix;
  logic        b_ov, b_fd;
  logic [11:0] b_lu, b_mu, b_ru, b_lm, b_mm, b_rm, b_ld, b_md, b_rd;
  logic [8:0]  b_row, b_col;

  int checks = 0;
  int failures = 0;

  window_gen_3x3 #(.IMG_W(SW), .IMG_H(SH), .PIX_W(12)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_pixel(a_pix),
    .frame_start(a_fs), .out_valid(a_ov),
    .win_lu(a_lu), .win_mu(a_mu), .win_ru(a_ru),
    .win_lm(a_lm), .win_mm(a_mm), .win_rm(a_rm),
    .win_ld(a_ld), .win_md(a_md), .win_rd(a_rd),
    .out_row(a_row), .out_col(a_col), .frame_done(a_fd)
  );

  window_gen_3x3 #(.IMG_W(BW), .IMG_H(BH), .PIX_W(12)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_pixel(b_pix),
    .frame_start(b_fs), .out_valid(b_ov),
    .win_lu(b_lu), .win_mu(b_mu), .win_ru(b_ru),
    .win_lm(b_lm), .win_mm(b_mm), .win_rm(b_rm),
    .win_ld(b_ld), .win_md(b_md), .win_rd(b_rd),
    .out_row(b_row), .out_col(b_col), .frame_done(b_fd)
  );

  function automatic logic [11:0] spx(input logic [3:0] t,
                                      input int r, input int c);
    logic [3:0] rr;
    logic [3:0] cc;
    rr = r[3:0];
    cc = c[3:0];
    return {t, rr, cc};
  endfunction

  function automatic logic [11:0] bpx(input int f, input int r,
                                      input int c);
    int t;
    t = f * 97 + r * 31 + c * 5 + 7;
    return t[11:0];
  endfunction

  task automatic drive_a(input logic v, input logic fs,
                         input logic [11:0] p);
    a_valid = v;
    a_fs    = fs;
    a_pix   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [3:0] t, input bit gaps,
                           input bit hand);
    int obs;
    bit ev;
    logic [107:0] got, exp;
    obs = 0;
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        if (gaps) begin
          for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
            drive_a(1'b0, 1'b0, 12'hfff);
            checks++;
            if (a_ov !== 1'b0 || a_fd !== 1'b0) begin
              failures++;
              $display("FAIL gap_idle ov=%b fd=%b want 0 0", a_ov, a_fd);
            end
          end
        end
        drive_a(1'b1, (r == 0 && c == 0), spx(t, r, c));
        ev = (r >= 2 && c >= 2);
        if (a_ov === 1'b1) obs++;
        got = {a_lu, a_mu, a_ru, a_lm, a_mm, a_rm, a_ld, a_md, a_rd};
        exp = {spx(t, r-2, c-2), spx(t, r-2, c-1), spx(t, r-2, c),
               spx(t, r-1, c-2), spx(t, r-1, c-1), spx(t, r-1, c),
               spx(t, r, c-2), spx(t, r, c-1), spx(t, r, c)};
        checks++;
        if (a_ov !== ev) begin
          failures++;
          $display("FAIL strobe t=%h (%0d,%0d) got=%b want=%b",
                   t, r, c, a_ov, ev);
        end else if (ev && (got !== exp || a_row !== 9'(r - 1) ||
                            a_col !== 9'(c - 1))) begin
          failures++;
          $display("FAIL window t=%h (%0d,%0d) got=%h rc=%0d,%0d want=%h",
                   t, r, c, got, a_row, a_col, exp);
        end
        checks++;
        if (a_fd !== (r == SH - 1 && c == SW - 1)) begin
          failures++;
          $display("FAIL frame_done t=%h (%0d,%0d) got=%b", t, r, c, a_fd);
        end
        if (hand && r == 2 && c == 2) begin
          checks++;
          if ({a_lu, a_mm, a_rd, a_ru, a_ld} !==
              {12'h000, 12'h011, 12'h022, 12'h002, 12'h020}) begin
            failures++;
            $display("FAIL first_window got=%h want=000011022002020",
                     {a_lu, a_mm, a_rd, a_ru, a_ld});
          end
        end
      end
    end
    drive_a(1'b0, 1'b0, 12'h000);
    checks++;
    if (a_fd !== 1'b0 || a_ov !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width fd=%b ov=%b want 0 0", a_fd, a_ov);
    end
    checks++;
    if (obs != 4) begin
      failures++;
      $display("FAIL strobe_count t=%h got=%0d want=4", t, obs);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    a_valid = 1'b0; a_fs = 1'b0; a_pix = '0;
    b_valid = 1'b0; b_fs = 1'b0; b_pix = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_ov, a_fd, b_ov, b_fd} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {a_ov, a_fd, b_ov, b_fd});
    end
    checks++;
    if ({a_lu, a_mm, a_rd, a_row, a_col} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {a_lu, a_mm, a_rd, a_row, a_col});
    end
    reset = 1'b0;
  endtask

  task automatic test_frame();
    run_frame(4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_gapped();
    run_frame(4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_no_sof();
    reset = 1'b1;
    drive_a(1'b0, 1'b0, 12'h000);
    reset = 1'b0;
    for (int i = 0; i < SW * SH + 3; i++) begin
      drive_a(1'b1, 1'b0, 12'he00 | 12'(i));
      checks++;
      if (a_ov !== 1'b0 || a_fd !== 1'b0) begin
        failures++;
        $display("FAIL no_sof i=%0d ov=%b fd=%b want 0 0", i, a_ov, a_fd);
      end
    end
    run_frame(4'h1, 1'b0, 1'b0);
  endtask

  task automatic test_restart();
    for (int i = 0; i < 2 * SW + 1; i++) begin
      drive_a(1'b1, (i == 0), spx(4'h2, i / SW, i % SW));
      checks++;
      if (a_ov !== 1'b0 || a_fd !== 1'b0) begin
        failures++;
        $display("FAIL abandoned i=%0d ov=%b fd=%b want 0 0", i, a_ov, a_fd);
      end
    end
    run_frame(4'h3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * SW + 2; i++) begin
      drive_a(1'b1, (i == 0), spx(4'h4, i / SW, i % SW));
    end
    reset = 1'b1;
    drive_a(1'b1, 1'b0, spx(4'h4, 2, 2));
    reset = 1'b0;
    checks++;
    if ({a_ov, a_fd} !== 2'b0 ||
        {a_lu, a_mm, a_rd, a_ru, a_row, a_col} !== '0) begin
      failures++;
      $display("FAIL reset_mid ov=%b fd=%b outs=%h want all 0", a_ov, a_fd,
               {a_lu, a_mm, a_rd, a_ru, a_row, a_col});
    end
    for (int i = 2 * SW + 3; i < SW * SH; i++) begin
      drive_a(1'b1, 1'b0, spx(4'h4, i / SW, i % SW));
      checks++;
      if (a_ov !== 1'b0 || a_fd !== 1'b0) begin
        failures++;
        $display("FAIL after_reset i=%0d ov=%b fd=%b want 0 0", i, a_ov, a_fd);
      end
    end
    run_frame(4'h5, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int obs;
    int fds;
    int nfail;
    bit ev;
    bit last;
    logic [107:0] got, exp;
    obs = 0;
    fds = 0;
    nfail = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < BH; r++) begin
        for (int c = 0; c < BW; c++) begin
          b_valid = 1'b1;
          b_fs    = (r == 0 && c == 0);
          b_pix   = bpx(f, r, c);
          @(posedge clk);
          #1;
          ev   = (r >= 2 && c >= 2);
          last = (r == BH - 1 && c == BW - 1);
          if (b_ov === 1'b1) obs++;
          if (b_fd === 1'b1) fds++;
          got = {b_lu, b_mu, b_ru, b_lm, b_mm, b_rm, b_ld, b_md, b_rd};
          exp = {bpx(f, r-2, c-2), bpx(f, r-2, c-1), bpx(f, r-2, c),
                 bpx(f, r-1, c-2), bpx(f, r-1, c-1), bpx(f, r-1, c),
                 bpx(f, r, c-2), bpx(f, r, c-1), bpx(f, r, c)};
          checks++;
          if (b_ov !== ev || b_fd !== last ||
              (ev && (got !== exp || b_row !== 9'(r - 1) ||
                      b_col !== 9'(c - 1)))) begin
            failures++;
            nfail++;
            if (nfail < 10)
              $display("FAIL b2b f=%0d (%0d,%0d) ov=%b fd=%b got=%h want=%h",
                       f, r, c, b_ov, b_fd, got, exp);
          end
        end
      end
    end
    b_valid = 1'b0;
    b_fs    = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs != 2 * (BW - 2) * (BH - 2)) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=%0d", obs,
               2 * (BW - 2) * (BH - 2));
    end
    checks++;
    if (fds != 2) begin
      failures++;
      $display("FAIL b2b_done got=%0d want=2", fds);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gapped();
    test_no_sof();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
